// File: rtl/ysyx_22051013_divu_if.sv
// Request/response bundle between the EXU and the iterative divider.
// The master is the EXU side; the slave is the divider.
interface ysyx_22051013_divu_if #(
    parameter int XLEN = 64
);
    logic            div_valid;
    logic            div_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_signed;
    logic            div_word;
    logic            div_rem;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output div_valid, dividend, divisor, div_signed, div_word, div_rem, flush, out_ready,
        input  div_ready, out_valid, result, busy
    );

    modport slave (
        input  div_valid, dividend, divisor, div_signed, div_word, div_rem, flush, out_ready,
        output div_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22051013_divu.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W variants.
// Define YSYX_22051013_DIVU_FASTPATH_EN to skip CALC for divide-by-zero and signed overflow.
module ysyx_22051013_divu #(
    parameter int XLEN = 64
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22051013_divu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = {{(XLEN-31){1'b1}}, 31'b0};

    state_t          state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] quo, rem, dsr, spec_res, result_r;
    logic            word_r, rem_sel_r, neg_q_r, neg_r_r, spec_r;

    function automatic logic [XLEN-1:0] fmt(input logic word, input logic [XLEN-1:0] v);
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] ext_op(input logic word, input logic sgn,
                                               input logic [XLEN-1:0] v);
        if (!word) return v;
        return sgn ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    // Operand decode on the request inputs, used only on the accept cycle.
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_res_c;
    logic            a_neg, b_neg, dbz, ovf, spec_c;

    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        spec_res_c = '0;
        a_ext      = ext_op(bus.div_word, bus.div_signed, bus.dividend);
        b_ext      = ext_op(bus.div_word, bus.div_signed, bus.divisor);
        a_neg      = bus.div_signed & a_ext[XLEN-1];
        b_neg      = bus.div_signed & b_ext[XLEN-1];
        a_mag      = a_neg ? -a_ext : a_ext;
        b_mag      = b_neg ? -b_ext : b_ext;
        dbz        = (b_ext == '0);
        ovf        = bus.div_signed && (b_ext == '1) &&
                     (a_ext == (bus.div_word ? MIN_WORD : MIN_FULL));
        spec_c     = dbz | ovf;
        if (dbz)      spec_res_c = bus.div_rem ? a_ext : '1;
        else if (ovf) spec_res_c = bus.div_rem ? '0 : a_ext;
        spec_res_c = fmt(bus.div_word, spec_res_c);
    end

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    logic [XLEN:0]   r_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin, fin_res;

    assign r_sh    = {rem, quo[XLEN-1]};
    assign diff    = r_sh - {1'b0, dsr};
    assign q_bit   = ~diff[XLEN];
    assign rem_nxt = q_bit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], q_bit};
    assign q_fin   = neg_q_r ? -quo_nxt : quo_nxt;
    assign r_fin   = neg_r_r ? -rem_nxt : rem_nxt;
    assign fin_res = spec_r ? spec_res : fmt(word_r, rem_sel_r ? r_fin : q_fin);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dsr       <= '0;
            spec_res  <= '0;
            result_r  <= '0;
            word_r    <= 1'b0;
            rem_sel_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            spec_r    <= 1'b0;
        end else if (bus.flush) begin
            state    <= IDLE;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.div_valid) begin
                    cnt       <= bus.div_word ? 7'd32 : 7'd64;
                    quo       <= bus.div_word ? {a_mag[31:0], 32'b0} : a_mag;
                    rem       <= '0;
                    dsr       <= b_mag;
                    spec_res  <= spec_res_c;
                    spec_r    <= spec_c;
                    word_r    <= bus.div_word;
                    rem_sel_r <= bus.div_rem;
                    neg_q_r   <= a_neg ^ b_neg;
                    neg_r_r   <= a_neg;
`ifdef YSYX_22051013_DIVU_FASTPATH_EN
                    if (spec_c) begin
                        state    <= DONE;
                        result_r <= spec_res_c;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        state    <= DONE;
                        result_r <= fin_res;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state    <= IDLE;
                    result_r <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_ready = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_r;
endmodule
